serial_add_ctrl: RTL and testbench

Bit-serial adder controller that sequences a single `fulladd` cell over WIDTH cycles to add two WIDTH-bit operands plus carry-in, LSB first. It is the sequencing and control layer around the existing one-bit full-adder datapath. It presents a start/busy/done handshake to the surrounding logic and holds the registered result until the next operation completes.

---
 rtl/serial_add_ctrl_pkg.sv | 12 +
 rtl/serial_add_ctrl_fulladd.sv | 14 +
 rtl/serial_add_ctrl.sv | 112 +++++++++++
 tb/tb_serial_add_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types for the bit-serial adder controller: FSM state encodings.
package serial_add_ctrl_pkg;

  // ST_RECOVER is an unused encoding; the FSM steers it straight back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_fulladd.sv
// One-bit full adder cell, purely combinational; the serial controller
// feeds it one operand bit pair per cycle.
module fulladd (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: sequences one fulladd cell over WIDTH cycles,
// LSB first, behind a start/busy/done handshake with a held registered result.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Only the upper WIDTH-1 bits of the partial sum are ever read back,
  // so the bit that would fall off the bottom is not stored.
  logic [WIDTH-2:0] s_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] s_next;
  logic             last_bit;

  fulladd u_fulladd (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign s_next   = {fa_sum, s_sh};
  assign last_bit = (cnt == LAST_CNT);

  // Handshake outputs decode straight from the state register.
  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, run WIDTH bits, pulse DONE once.
  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE:    state_next = start ? ST_RUN : ST_IDLE;
      ST_RUN:     state_next = last_bit ? ST_DONE : ST_RUN;
      ST_DONE:    state_next = ST_IDLE;
      ST_RECOVER: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Datapath: capture operands, shift one bit per RUN cycle, publish result on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= cin;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          s_sh  <= s_next[WIDTH-1:1];
          carry <= fa_cout;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            sum  <= s_next;
            cout <= fa_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl with an expected-result scoreboard.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks = 0;
  int errors = 0;

  logic [WIDTH:0] exp_q[$];

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Called at a falling edge; leaves the bench at the falling edge after the accepting edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic c, input bit expect_result);
    a_in  = a;
    b_in  = b;
    cin   = c;
    start = 1'b1;
    if (expect_result) exp_q.push_back({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c});
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done, checking latency, busy length and the scoreboard result.
  task automatic awaitResult(input string tag, input bit disturb);
    int n = 1;
    int busy_cycles = 0;
    logic [WIDTH:0] expv;
    while (!done && n < 40) begin
      if (busy) busy_cycles++;
      if (disturb) begin
        start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
        a_in  = WIDTH'($urandom);
        b_in  = WIDTH'($urandom);
        cin   = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    checkOutput({tag, "_latency"}, n, WIDTH + 1);
    checkOutput({tag, "_busy_cycles"}, busy_cycles, WIDTH);
    checkOutput({tag, "_busy_in_done"}, busy, 0);
    if (exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      checkOutput({tag, "_result"}, {cout, sum}, expv);
    end else begin
      checkOutput({tag, "_scoreboard_empty"}, exp_q.size(), 1);
    end
    @(negedge clk);
    checkOutput({tag, "_done_single"}, done, 0);
  endtask

  initial begin
    int last_k;
    int pulses;
    logic [WIDTH:0] expv;

    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    cin   = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_sum", sum, 0);
    checkOutput("rst_cout", cout, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed operations");
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b1);
    awaitResult("zero", 1'b0);
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b1);
    awaitResult("ff_plus_1", 1'b0);
    checkOutput("ff_plus_1_const", {cout, sum}, 9'h100);
    applyStimulus(8'hA5, 8'h5A, 1'b1, 1'b1);
    awaitResult("a5_5a_c1", 1'b0);
    checkOutput("a5_5a_c1_const", {cout, sum}, 9'h100);
    applyStimulus(8'h7F, 8'h01, 1'b0, 1'b1);
    awaitResult("7f_plus_1", 1'b0);
    checkOutput("7f_plus_1_const", {cout, sum}, 9'h080);

    $display("[TB] start pulses and operand changes during RUN");
    applyStimulus(8'h3C, 8'h41, 1'b1, 1'b1);
    awaitResult("disturb", 1'b1);
    repeat (3) begin
      @(negedge clk);
      checkOutput("disturb_no_extra_done", done, 0);
      checkOutput("disturb_no_extra_busy", busy, 0);
    end
    checkOutput("disturb_result_held", {cout, sum}, 9'h07E);

    $display("[TB] reset in the middle of RUN");
    applyStimulus(8'h3C, 8'h0F, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_sum", sum, 0);
    checkOutput("midrst_cout", cout, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_idle", busy, 0);
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b1);
    awaitResult("after_rst", 1'b0);
    checkOutput("after_rst_const", {cout, sum}, 9'h046);

    $display("[TB] start held high");
    a_in  = 8'h01;
    b_in  = 8'h01;
    cin   = 1'b0;
    start = 1'b1;
    repeat (3) exp_q.push_back(9'h002);
    last_k = -1;
    pulses = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (busy && done) checkOutput("hold_busy_and_done", {busy, done}, 2'b00);
      if (done) begin
        pulses++;
        if (pulses == 1) checkOutput("hold_first_done", k, 9);
        if (last_k >= 0) checkOutput("hold_spacing", k - last_k, 10);
        last_k = k;
        if (exp_q.size() > 0) begin
          expv = exp_q.pop_front();
          checkOutput("hold_result", {cout, sum}, expv);
        end else begin
          checkOutput("hold_scoreboard_empty", exp_q.size(), 1);
        end
      end
    end
    start = 1'b0;
    checkOutput("hold_pulses", pulses, 3);
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
